// File: rtl/uart_rcv_ctrl.sv
// uart_rcv_ctrl: receive controller for the UART receive path.
// Synchronizes the serial line and validates the start bit. Paces the external
// 9-bit shift register with a mid-bit strobe, checks the stop bit, and loads
// the received byte into a host-visible buffer with ready/overrun/framing status.
module uart_rcv_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic [7:0] packet_data,
  input  logic       stop_bit,
  input  logic       data_read,
  output logic       rx_sync,
  output logic       shift_strobe,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT_IDX = 4'd8;

  typedef enum logic [1:0] {IDLE, START_CHK, RECEIVE, CHECK} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic          start_edge;
  logic          load;
  logic          fe_set;
  logic          fe_clr;

  assign rx_sync    = sync2;
  assign start_edge = prev & ~sync2;
  assign busy       = (state != IDLE);

  // Two-flop synchronizer plus one-cycle delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next-state, counter and strobe decode
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_strobe = 1'b0;
    load         = 1'b0;
    fe_set       = 1'b0;
    fe_clr       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
        if (start_edge) begin
          state_nxt = START_CHK;
          fe_clr    = 1'b1;
        end
      end
      START_CHK: begin
        if (cnt == HALF_M1) begin
          // Mid start bit: a high line here means the falling edge was a glitch
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_sync ? IDLE : RECEIVE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RECEIVE: begin
        if (cnt == LAST) begin
          cnt_nxt      = '0;
          shift_strobe = 1'b1;
          bit_cnt_nxt  = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT_IDX) state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CHECK: begin
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
        load        = stop_bit;
        fe_set      = ~stop_bit;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // Host buffer and status flags; a load takes priority over a host read
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= 8'h00;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (load) begin
        rx_data    <= packet_data;
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (fe_set)      framing_error <= 1'b1;
      else if (fe_clr) framing_error <= 1'b0;
    end
  end

endmodule
